// File: rtl/cl_dmem_port_pkg.sv
// Shared types for the data-memory port: FSM states, request bundle, byte-lane constants.
// Pure declarations; no latency and no backpressure of its own.
package cl_dmem_port_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_LANES  = 4;

    localparam logic [DMEM_LANES-1:0] LANE_MASK_BYTE0 = 4'b0001;
    localparam logic [DMEM_LANES-1:0] LANE_MASK_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_LANES-1:0]  mask;
    } dmem_req_t;

endpackage

// File: rtl/cl_dmem_lane.sv
// Byte-lane steering: store mask/replicated wdata from the op, load byte extraction from the response.
// Purely combinational, zero latency; no flow control.
module cl_dmem_lane
    import cl_dmem_port_pkg::*;
(
    input  logic                   i_byte,
    input  logic [DMEM_ADDR_W-1:0] i_addr,
    input  logic [DMEM_DATA_W-1:0] i_store_data,
    input  logic                   i_ld_byte,
    input  logic [1:0]             i_ld_boff,
    input  logic [DMEM_DATA_W-1:0] i_resp_data,
    output logic [DMEM_ADDR_W-1:0] o_addr,
    output logic [DMEM_LANES-1:0]  o_mask,
    output logic [DMEM_DATA_W-1:0] o_wdata,
    output logic [DMEM_DATA_W-1:0] o_load_data
);

    logic [7:0] w_resp_byte;

    assign o_addr      = {i_addr[DMEM_ADDR_W-1:2], 2'b00};
    assign w_resp_byte = i_resp_data[{i_ld_boff, 3'b000} +: 8];

    always_comb begin
        o_mask      = LANE_MASK_WORD;
        o_wdata     = i_store_data;
        o_load_data = i_resp_data;
        if (i_byte) begin
            o_mask  = LANE_MASK_BYTE0 << i_addr[1:0];
            o_wdata = {DMEM_LANES{i_store_data[7:0]}};
        end
        if (i_ld_byte) begin
            o_load_data = {{(DMEM_DATA_W-8){1'b0}}, w_resp_byte};
        end
    end

endmodule

// File: rtl/cl_dmem_port.sv
// Load/store port between execute and data memory; store stalls >=2 cycles, load >=3 with data in the 4th.
// Holds the pipeline while mem_req_ready_i is low or the response is pending; DMEM_MISALIGN_TRAP_EN traps misaligned word ops.
module cl_dmem_port
    import cl_dmem_port_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              is_byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              err_o,
    output logic              misalign_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    output logic [3:0]        mem_req_mask_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i
);

    localparam int               CNT_W    = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    dmem_req_t         r_req;
    logic              r_is_load;
    logic              r_is_byte;
    logic [1:0]        r_boff;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_load_valid;
    logic              r_err;
    logic              r_misalign;
    logic [DATA_W-1:0] r_load_data;

    logic              w_op;
    logic              w_misalign;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_mask;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_data;

    assign w_op      = valid_i & (is_load_i | is_store_i);
    assign w_timeout = (r_cnt == CNT_LAST);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ~is_byte_i & (addr_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Store steering is taken from the live inputs at capture; load extraction uses the captured offset.
    cl_dmem_lane u_lane (
        .i_byte       (is_byte_i),
        .i_addr       (addr_i),
        .i_store_data (store_data_i),
        .i_ld_byte    (r_is_byte),
        .i_ld_boff    (r_boff),
        .i_resp_data  (mem_resp_data_i),
        .o_addr       (w_addr),
        .o_mask       (w_mask),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_comb begin
        w_state_nxt     = r_state;
        stall_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_o = w_op;
                if (w_op) begin
                    w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall_o         = 1'b1;
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    w_state_nxt = r_is_load ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (mem_resp_valid_i || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_is_load    <= 1'b0;
            r_is_byte    <= 1'b0;
            r_boff       <= 2'b00;
            r_cnt        <= '0;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
            r_misalign   <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
            r_misalign   <= 1'b0;
            if (r_state == ST_IDLE && w_op) begin
                r_req.we    <= ~is_load_i;
                r_req.addr  <= w_addr;
                r_req.wdata <= is_load_i ? '0 : w_wdata;
                r_req.mask  <= w_mask;
                r_is_load   <= is_load_i;
                r_is_byte   <= is_byte_i;
                r_boff      <= addr_i[1:0];
                r_misalign  <= w_misalign;
            end
            if (r_state == ST_REQ) begin
                r_cnt <= '0;
            end
            // The timeout flag and load data both land in the single DONE cycle as pulses.
            if (r_state == ST_WAIT) begin
                if (mem_resp_valid_i) begin
                    r_load_data  <= w_load_data;
                    r_load_valid <= 1'b1;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign load_valid_o    = r_load_valid;
    assign load_data_o     = r_load_data;
    assign err_o           = r_err;
    assign misalign_o      = r_misalign;
    assign mem_req_we_o    = r_req.we;
    assign mem_req_addr_o  = r_req.addr;
    assign mem_req_wdata_o = r_req.wdata;
    assign mem_req_mask_o  = r_req.mask;

endmodule

// File: tb/tb_cl_dmem_port.sv
// Randomized and directed bench for cl_dmem_port against a behavioural lane/latency model.
module tb_cl_dmem_port;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset_n;
    logic        valid_i, is_load_i, is_store_i, is_byte_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, load_valid_o, err_o, misalign_o;
    logic [31:0] load_data_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o;
    logic [3:0]  mem_req_mask_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;

    int checks = 0;
    int passes = 0;

    cl_dmem_port #(.ADDR_W(32), .DATA_W(32), .RESP_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .is_byte_i(is_byte_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .stall_o(stall_o), .load_valid_o(load_valid_o),
        .load_data_o(load_data_o), .err_o(err_o), .misalign_o(misalign_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_mask_o(mem_req_mask_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          stall, nreq, accepts, lv, lv_cyc, err, err_cyc, mis;
        logic        we;
        logic [31:0] addr, wdata, ld_data;
        logic [3:0]  mask;
        bit          unstable, timed_out;
    } res_t;

    // Reference model: lane rules as plain arithmetic, latency from the state sequence.
    function automatic logic [31:0] m_addr(input logic [31:0] a);
        return a - (a % 4);
    endfunction
    function automatic logic [3:0] m_mask(input bit byt, input logic [31:0] a);
        return byt ? 4'(1 << (a % 4)) : 4'hF;
    endfunction
    function automatic logic [31:0] m_wdata(input bit byt, input logic [31:0] sd);
        return byt ? (sd % 256) * 32'h0101_0101 : sd;
    endfunction
    function automatic logic [31:0] m_load(input bit byt, input logic [31:0] a, input logic [31:0] rsp);
        return byt ? (rsp >> (8 * (a % 4))) % 256 : rsp;
    endfunction
    function automatic int m_stall(input bit ld, input int rdy, input int rsp);
        return ld ? rdy + rsp + 3 : rdy + 2;
    endfunction

    // Drives one op and a memory with programmable ready/response delays; records what was observed.
    task automatic run_op(input bit ld, input bit byt, input logic [31:0] a, input logic [31:0] sd,
                          input int rdy_dly, input int rsp_dly, input bit give_rsp,
                          input logic [31:0] rsp, output res_t r);
        int acc_cyc = -1;
        int tail = -1;
        r.stall = 0; r.nreq = 0; r.accepts = 0; r.lv = 0; r.lv_cyc = -1; r.err = 0;
        r.err_cyc = -1; r.mis = 0; r.we = 0; r.addr = 0; r.wdata = 0; r.ld_data = 0;
        r.mask = 0; r.unstable = 0; r.timed_out = 1;
        valid_i = 1; is_load_i = ld; is_store_i = !ld; is_byte_i = byt; addr_i = a; store_data_i = sd;
        mem_req_ready_i = (rdy_dly == 0); mem_resp_valid_i = 0; mem_resp_data_i = 32'hDEAD_BEEF;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (stall_o) r.stall++;
            if (mem_req_valid_o) begin
                if (r.nreq == 0) begin
                    r.we = mem_req_we_o; r.addr = mem_req_addr_o;
                    r.wdata = mem_req_wdata_o; r.mask = mem_req_mask_o;
                end else if ({mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_mask_o}
                             !== {r.we, r.addr, r.wdata, r.mask}) begin
                    r.unstable = 1;
                end
                r.nreq++;
                if (mem_req_ready_i) begin r.accepts++; acc_cyc = cyc; end
            end
            if (load_valid_o) begin r.lv++; r.lv_cyc = cyc; r.ld_data = load_data_o; end
            if (err_o) begin r.err++; r.err_cyc = cyc; end
            if (misalign_o) r.mis++;
            if (tail > 0) tail--;
            else if (cyc > 0 && !stall_o && tail < 0) tail = 2;
            if (tail == 0) begin r.timed_out = 0; break; end
            @(negedge clk);
            valid_i = 0;
            mem_req_ready_i = (r.accepts == 0) && (r.nreq >= rdy_dly);
            mem_resp_valid_i = give_rsp && acc_cyc >= 0 && (cyc + 1 == acc_cyc + 1 + rsp_dly);
            mem_resp_data_i = mem_resp_valid_i ? rsp : 32'hDEAD_BEEF;
        end
        mem_resp_valid_i = 0; mem_req_ready_i = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; valid_i = 0; is_load_i = 0; is_store_i = 0; is_byte_i = 0;
        addr_i = 0; store_data_i = 0; mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({stall_o, mem_req_valid_o, load_valid_o, err_o, misalign_o} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {stall_o, mem_req_valid_o, load_valid_o, err_o, misalign_o});
        else passes++;
        checks++; if ({mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_mask_o, load_data_o} !== '0)
            $display("FAIL reset_data: got %h %h %h %h expected zeros", mem_req_addr_o, mem_req_wdata_o, mem_req_mask_o, load_data_o);
        else passes++;
        reset_n = 1;
    endtask

    task automatic test_sb_immediate();
        res_t r;
        run_op(0, 1, 32'h1003, 32'hA5, 0, 0, 0, 0, r);
        checks++; if ({r.we, r.addr, r.mask} !== {1'b1, 32'h1000, 4'b1000})
            $display("FAIL sb_req: got we=%b addr=%h mask=%b expected 1 00001000 1000", r.we, r.addr, r.mask);
        else passes++;
        checks++; if (r.wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", r.wdata);
        else passes++;
        checks++; if (r.stall !== 2) $display("FAIL sb_stall: got %0d expected 2", r.stall);
        else passes++;
        checks++; if (r.accepts !== 1 || r.lv !== 0) $display("FAIL sb_accepts: got %0d lv=%0d expected 1 lv=0", r.accepts, r.lv);
        else passes++;
    endtask

    task automatic test_lbu_delayed();
        res_t r;
        run_op(1, 1, 32'h2001, 0, 0, 3, 1, 32'h1122_3344, r);
        checks++; if (r.ld_data !== 32'h0000_0033) $display("FAIL lbu_data: got %h expected 00000033", r.ld_data);
        else passes++;
        checks++; if (r.lv !== 1) $display("FAIL lbu_pulse: got %0d pulses expected 1", r.lv);
        else passes++;
        checks++; if (r.lv_cyc !== 6) $display("FAIL lbu_latency: got cycle %0d expected 6", r.lv_cyc);
        else passes++;
    endtask

    task automatic test_sw_backpressure();
        res_t r;
        run_op(0, 0, 32'h0000_4440, 32'h1234_5678, 5, 0, 0, 0, r);
        checks++; if (r.unstable !== 0 || r.nreq !== 6) $display("FAIL sw_hold: got unstable=%0d valid_cycles=%0d expected 0 6", r.unstable, r.nreq);
        else passes++;
        checks++; if (r.stall !== 7) $display("FAIL sw_stall: got %0d expected 7", r.stall);
        else passes++;
        checks++; if (r.accepts !== 1 || r.mask !== 4'hF || r.wdata !== 32'h1234_5678)
            $display("FAIL sw_req: got acc=%0d mask=%h wdata=%h expected 1 f 12345678", r.accepts, r.mask, r.wdata);
        else passes++;
    endtask

    task automatic test_lw_timeout();
        res_t r;
        run_op(1, 0, 32'h0000_5000, 0, 0, 0, 0, 0, r);
        checks++; if (r.err !== 1 || r.lv !== 0) $display("FAIL timeout_err: got err=%0d lv=%0d expected 1 0", r.err, r.lv);
        else passes++;
        checks++; if (r.err_cyc !== TIMEOUT + 2) $display("FAIL timeout_cycle: got %0d expected %0d", r.err_cyc, TIMEOUT + 2);
        else passes++;
        checks++; if (r.timed_out !== 0 || r.stall !== TIMEOUT + 2) $display("FAIL timeout_idle: got stall=%0d hung=%0d expected %0d 0", r.stall, r.timed_out, TIMEOUT + 2);
        else passes++;
    endtask

    task automatic test_reset_in_wait();
        res_t r;
        int bad = 0;
        valid_i = 1; is_load_i = 1; is_store_i = 0; is_byte_i = 0; addr_i = 32'h60; mem_req_ready_i = 1;
        @(negedge clk); valid_i = 0;
        @(negedge clk); mem_req_ready_i = 0; #1;
        checks++; if (stall_o !== 1) $display("FAIL rst_wait_pre: got stall %b expected 1", stall_o);
        else passes++;
        reset_n = 0;
        @(negedge clk); #1;
        checks++; if ({stall_o, mem_req_valid_o, load_valid_o, err_o, mem_req_addr_o, load_data_o} !== '0)
            $display("FAIL rst_wait_outs: got stall=%b req=%b lv=%b addr=%h expected all 0", stall_o, mem_req_valid_o, load_valid_o, mem_req_addr_o);
        else passes++;
        reset_n = 1; mem_resp_valid_i = 1; mem_resp_data_i = 32'hCAFE_F00D;
        @(negedge clk); mem_resp_valid_i = 0;
        repeat (3) begin #1; if (load_valid_o || stall_o || err_o) bad++; @(negedge clk); end
        checks++; if (bad !== 0) $display("FAIL rst_wait_ignored: got %0d active cycles expected 0", bad);
        else passes++;
        run_op(1, 0, 32'h64, 0, 0, 0, 1, 32'h7777_0001, r);
        checks++; if (r.lv !== 1 || r.ld_data !== 32'h7777_0001) $display("FAIL rst_wait_next: got lv=%0d data=%h expected 1 77770001", r.lv, r.ld_data);
        else passes++;
    endtask

    task automatic test_misalign();
        res_t r;
        run_op(1, 0, 32'h3002, 0, 0, 0, 1, 32'h0BAD_F00D, r);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (r.mis !== 1 || r.nreq !== 0 || r.lv !== 0)
            $display("FAIL misalign_trap: got mis=%0d req=%0d lv=%0d expected 1 0 0", r.mis, r.nreq, r.lv);
        else passes++;
`else
        checks++; if (r.mis !== 0 || r.nreq !== 1 || r.addr !== 32'h3000 || r.lv !== 1)
            $display("FAIL misalign_off: got mis=%0d req=%0d addr=%h lv=%0d expected 0 1 00003000 1", r.mis, r.nreq, r.addr, r.lv);
        else passes++;
`endif
    endtask

    task automatic test_random();
        res_t r;
        for (int i = 0; i < 40; i++) begin
            bit ld = 1'($urandom_range(1));
            bit byt = 1'($urandom_range(1));
            logic [31:0] a = $urandom;
            logic [31:0] sd = $urandom;
            logic [31:0] rsp = $urandom;
            int rd = $urandom_range(3);
            int sp = $urandom_range(4);
`ifdef DMEM_MISALIGN_TRAP_EN
            if (!byt) a = m_addr(a);
`endif
            run_op(ld, byt, a, sd, rd, sp, 1, rsp, r);
            checks++; if (r.addr !== m_addr(a) || r.mask !== m_mask(byt, a) || r.we !== !ld || r.accepts !== 1)
                $display("FAIL rnd_req[%0d]: got addr=%h mask=%h we=%b acc=%0d expected %h %h %b 1", i, r.addr, r.mask, r.we, r.accepts, m_addr(a), m_mask(byt, a), !ld);
            else passes++;
            checks++; if (r.stall !== m_stall(ld, rd, sp) || r.lv !== int'(ld) || r.timed_out)
                $display("FAIL rnd_timing[%0d]: got stall=%0d lv=%0d expected %0d %0d", i, r.stall, r.lv, m_stall(ld, rd, sp), ld);
            else passes++;
            if (ld) begin
                checks++; if (r.ld_data !== m_load(byt, a, rsp))
                    $display("FAIL rnd_load[%0d]: got %h expected %h", i, r.ld_data, m_load(byt, a, rsp));
                else passes++;
            end else begin
                checks++; if (r.wdata !== m_wdata(byt, sd))
                    $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, r.wdata, m_wdata(byt, sd));
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_sb_immediate();
        test_lbu_delayed();
        test_sw_backpressure();
        test_lw_timeout();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
